// File: rtl/pw_lockout_ctrl.sv
// pw_lockout_ctrl
//   Access-policy controller fed by the password-check verdict. A match opens
//   the door for a timed window. Consecutive mismatches are counted, and
//   MAX_FAIL of them in a row block further verdicts for a timed lockout.
//
//   Optional feature macro: LOCKOUT_ESCALATE_EN
//     When this macro is defined, each lockout doubles the next lockout length,
//     up to a maximum of 4x. Only a match or rst returns the length to 1x.
//
// Ports
//   clk_100       in   100 Hz system tick clock
//   rst           in   asynchronous, active-high reset
//   result_valid  in   1-cycle pulse: one verdict available
//   result_match  in   verdict (1 = match); sampled only with result_valid
//   close         in   ends the OPEN window early
//   in_ready      out  1 while ARMED (verdicts accepted)
//   door_open     out  1 while OPEN
//   locked        out  1 while LOCKED
//   fail_cnt      out  consecutive mismatches
//   timer         out  remaining cycles of the OPEN/LOCKED window, else 0
//   lock_event    out  1-cycle pulse on entry to LOCKED
module pw_lockout_ctrl #(
    parameter int MAX_FAIL   = 3,
    parameter int LOCK_TICKS = 3000,
    parameter int OPEN_TICKS = 500,
    parameter int CNT_W      = 14
) (
    input  logic             clk_100,
    input  logic             rst,
    input  logic             result_valid,
    input  logic             result_match,
    input  logic             close,
    output logic             in_ready,
    output logic             door_open,
    output logic             locked,
    output logic [2:0]       fail_cnt,
    output logic [CNT_W-1:0] timer,
    output logic             lock_event
);

    typedef enum logic [1:0] {
        ARMED  = 2'b00,
        OPEN   = 2'b01,
        LOCKED = 2'b10
    } state_t;

    localparam logic [2:0]       FAIL_LAST = 3'(MAX_FAIL - 1);
    localparam logic [2:0]       FAIL_MAX  = 3'(MAX_FAIL);
    localparam logic [CNT_W-1:0] OPEN_LOAD = CNT_W'(OPEN_TICKS - 1);
    localparam logic [CNT_W-1:0] LOCK_BASE = CNT_W'(LOCK_TICKS);

    state_t           state, state_nxt;
    logic [2:0]       fail_nxt;
    logic [CNT_W-1:0] timer_nxt;
    logic             event_nxt;
    logic [CNT_W-1:0] lock_len;

`ifdef LOCKOUT_ESCALATE_EN
    logic [1:0] lock_level, level_nxt;
    assign lock_len = LOCK_BASE << lock_level;
`else
    assign lock_len = LOCK_BASE;
`endif

    always_comb begin
        state_nxt = state;
        fail_nxt  = fail_cnt;
        timer_nxt = timer;
        event_nxt = 1'b0;
`ifdef LOCKOUT_ESCALATE_EN
        level_nxt = lock_level;
`endif
        case (state)
            ARMED: begin
                if (result_valid) begin
                    if (result_match) begin
                        state_nxt = OPEN;
                        timer_nxt = OPEN_LOAD;
                        fail_nxt  = 3'd0;
`ifdef LOCKOUT_ESCALATE_EN
                        level_nxt = 2'd0;
`endif
                    end else if (fail_cnt >= FAIL_LAST) begin
                        state_nxt = LOCKED;
                        fail_nxt  = FAIL_MAX;
                        timer_nxt = lock_len - 1'b1;
                        event_nxt = 1'b1;
`ifdef LOCKOUT_ESCALATE_EN
                        // The current level sets this lockout's length. The
                        // next lockout uses the bumped level.
                        level_nxt = (lock_level >= 2'd2) ? 2'd2 : lock_level + 2'd1;
`endif
                    end else begin
                        fail_nxt = fail_cnt + 3'd1;
                    end
                end
            end
            OPEN: begin
                // close wins over expiry and over any verdict; in_ready is low here
                if (close || timer == '0) begin
                    state_nxt = ARMED;
                    timer_nxt = '0;
                end else begin
                    timer_nxt = timer - 1'b1;
                end
            end
            LOCKED: begin
                // verdicts and close are deaf here, expiry cycle included
                if (timer == '0) begin
                    state_nxt = ARMED;
                    fail_nxt  = 3'd0;
                end else begin
                    timer_nxt = timer - 1'b1;
                end
            end
            default: begin
                // unreachable encoding 2'b11: recover to a clean ARMED
                state_nxt = ARMED;
                timer_nxt = '0;
                fail_nxt  = 3'd0;
            end
        endcase
    end

    // The flags are registered from state_nxt. This way they change on the
    // same edge as the state and show correctly in the first cycle of it.
    always_ff @(posedge clk_100 or posedge rst) begin
        if (rst) begin
            state      <= ARMED;
            fail_cnt   <= 3'd0;
            timer      <= '0;
            lock_event <= 1'b0;
            in_ready   <= 1'b1;
            door_open  <= 1'b0;
            locked     <= 1'b0;
`ifdef LOCKOUT_ESCALATE_EN
            lock_level <= 2'd0;
`endif
        end else begin
            state      <= state_nxt;
            fail_cnt   <= fail_nxt;
            timer      <= timer_nxt;
            lock_event <= event_nxt;
            in_ready   <= (state_nxt == ARMED);
            door_open  <= (state_nxt == OPEN);
            locked     <= (state_nxt == LOCKED);
`ifdef LOCKOUT_ESCALATE_EN
            lock_level <= level_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_pw_lockout_ctrl.sv
// Scoreboard bench for pw_lockout_ctrl (MAX_FAIL=3, LOCK_TICKS=10, OPEN_TICKS=5).
// Each step drives one cycle of inputs and queues the outputs that should
// appear after the next clock edge. The monitor pops and compares these
// values on every falling edge.
module tb_pw_lockout_ctrl;
    localparam int CNT_W = 14;

    logic             clk_100 = 1'b0;
    logic             rst = 1'b1;
    logic             result_valid = 1'b0;
    logic             result_match = 1'b0;
    logic             close = 1'b0;
    logic             in_ready, door_open, locked, lock_event;
    logic [2:0]       fail_cnt;
    logic [CNT_W-1:0] timer;

    pw_lockout_ctrl #(
        .MAX_FAIL(3), .LOCK_TICKS(10), .OPEN_TICKS(5), .CNT_W(CNT_W)
    ) dut (
        .clk_100(clk_100), .rst(rst), .result_valid(result_valid),
        .result_match(result_match), .close(close), .in_ready(in_ready),
        .door_open(door_open), .locked(locked), .fail_cnt(fail_cnt),
        .timer(timer), .lock_event(lock_event)
    );

    always #5 clk_100 = ~clk_100;

    typedef struct packed {
        logic             door;
        logic             lck;
        logic             rdy;
        logic [2:0]       fail;
        logic [CNT_W-1:0] tmr;
        logic             ev;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_step  = 0;

    function automatic exp_t ex(logic d, logic l, logic r, logic [2:0] f, int t, logic ev);
        exp_t e;
        e.door = d; e.lck = l; e.rdy = r; e.fail = f; e.tmr = CNT_W'(t); e.ev = ev;
        return e;
    endfunction

    function automatic exp_t st_a(logic [2:0] f);     return ex(1'b0, 1'b0, 1'b1, f, 0, 1'b0);    endfunction
    function automatic exp_t st_o(int t);             return ex(1'b1, 1'b0, 1'b0, 3'd0, t, 1'b0); endfunction
    function automatic exp_t st_l(int t, logic ev);   return ex(1'b0, 1'b1, 1'b0, 3'd3, t, ev);   endfunction

    function automatic void compare(string tag, exp_t e);
        exp_t a;
        a = {door_open, locked, in_ready, fail_cnt, timer, lock_event};
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got door=%0b locked=%0b ready=%0b fail=%0d timer=%0d ev=%0b, want door=%0b locked=%0b ready=%0b fail=%0d timer=%0d ev=%0b",
                     tag, a.door, a.lck, a.rdy, a.fail, a.tmr, a.ev,
                     e.door, e.lck, e.rdy, e.fail, e.tmr, e.ev);
        end
    endfunction

    // monitor: DUT outputs are stable on the falling edge
    always @(negedge clk_100) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            n_step++;
            compare($sformatf("step%0d", n_step), e);
        end
    end

    task automatic step(logic r, logic v, logic m, logic c, exp_t e);
        @(negedge clk_100);
        #1;
        rst = r; result_valid = v; result_match = m; close = c;
        q.push_back(e);
    endtask

    task automatic idle(exp_t e);
        step(1'b0, 1'b0, 1'b0, 1'b0, e);
    endtask

    // three mismatches from fail_cnt=0, a lockout of len cycles, then back to ARMED
    task automatic lockout(int len);
        step(1'b0, 1'b1, 1'b0, 1'b0, st_a(3'd1));
        step(1'b0, 1'b1, 1'b0, 1'b0, st_a(3'd2));
        step(1'b0, 1'b1, 1'b0, 1'b0, st_l(len - 1, 1'b1));
        for (int t = len - 2; t >= 0; t--) idle(st_l(t, 1'b0));
        idle(st_a(3'd0));
    endtask

    initial begin
        // reset state
        step(1'b1, 1'b0, 1'b0, 1'b0, st_a(3'd0));
        step(1'b1, 1'b0, 1'b0, 1'b0, st_a(3'd0));
        idle(st_a(3'd0));

        // match -> 5 open cycles (timer 4..0), then ARMED
        step(1'b0, 1'b1, 1'b1, 1'b0, st_o(4));
        for (int t = 3; t >= 0; t--) idle(st_o(t));
        idle(st_a(3'd0));
        idle(st_a(3'd0));

        // mismatches 1, (gap), 2, then lockout of 10. During the lockout, match
        // verdicts and close are ignored, including in the expiry cycle.
        step(1'b0, 1'b1, 1'b0, 1'b0, st_a(3'd1));
        idle(st_a(3'd1));
        step(1'b0, 1'b1, 1'b0, 1'b0, st_a(3'd2));
        step(1'b0, 1'b1, 1'b0, 1'b0, st_l(9, 1'b1));
        for (int t = 8; t >= 0; t--)
            step(1'b0, (t == 6 || t == 5), 1'b1, (t == 5), st_l(t, 1'b0));
        step(1'b0, 1'b1, 1'b1, 1'b1, st_a(3'd0));
        idle(st_a(3'd0));

        // OPEN ignores verdicts; close at timer=2 -> ARMED
        step(1'b0, 1'b1, 1'b1, 1'b0, st_o(4));
        step(1'b0, 1'b1, 1'b0, 1'b0, st_o(3));
        idle(st_o(2));
        step(1'b0, 1'b0, 1'b0, 1'b1, st_a(3'd0));
        idle(st_a(3'd0));

        // close together with a verdict: close wins and the verdict is dropped
        step(1'b0, 1'b1, 1'b1, 1'b0, st_o(4));
        step(1'b0, 1'b1, 1'b1, 1'b1, st_a(3'd0));
        idle(st_a(3'd0));

        // a match clears a partial fail count
        step(1'b0, 1'b1, 1'b0, 1'b0, st_a(3'd1));
        step(1'b0, 1'b1, 1'b1, 1'b0, st_o(4));
        step(1'b0, 1'b0, 1'b0, 1'b1, st_a(3'd0));

        // asynchronous rst at LOCKED timer=5
        step(1'b0, 1'b1, 1'b0, 1'b0, st_a(3'd1));
        step(1'b0, 1'b1, 1'b0, 1'b0, st_a(3'd2));
        step(1'b0, 1'b1, 1'b0, 1'b0, st_l(9, 1'b1));
        for (int t = 8; t >= 5; t--) idle(st_l(t, 1'b0));
        @(negedge clk_100);
        #1;
        rst = 1'b1; result_valid = 1'b0;
        #1;
        compare("async_rst", st_a(3'd0));
        step(1'b1, 1'b0, 1'b0, 1'b0, st_a(3'd0));
        idle(st_a(3'd0));

        // two back-to-back lockouts, then a match, then another lockout
        lockout(10);
`ifdef LOCKOUT_ESCALATE_EN
        lockout(20);
`else
        lockout(10);
`endif
        step(1'b0, 1'b1, 1'b1, 1'b0, st_o(4));
        step(1'b0, 1'b0, 1'b0, 1'b1, st_a(3'd0));
        lockout(10);

        // drain: the monitor should have emptied the queue
        repeat (3) @(negedge clk_100);
        #1;
        if (q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
